barrel_shift: RTL and testbench

//   Parameterised logarithmic barrel shifter with a registered output.

---
 rtl/barrel_pkg.sv | 24 ++
 rtl/barrel_stage.sv | 41 ++++
 rtl/barrel_shift.sv | 80 ++++++++
 tb/tb_barrel_shift.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg
//   Shared definitions for the barrel shifter slice:
//   - DIR_LEFT / DIR_RIGHT : encodings of the direction input
//   - log2w()              : number of select bits / mux stages for a given width
package barrel_pkg;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Ceiling log2 of depth; used for the shift-amount width and stage count.
  function automatic int log2w(input int depth);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < depth) begin
        w = k + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// barrel_stage
//   One fixed-distance stage of the logarithmic shifter. When en is high the
//   word is moved SHIFT positions toward the MSB; the vacated low bits are
//   zero (ROTATE=0) or refilled with the bits pushed out of the top (ROTATE=1).
//   When en is low the word passes through unchanged.
// Ports
//   in   input  DEPTH  word from the previous stage
//   en   input  1      apply this stage's shift
//   out  output DEPTH  word to the next stage
module barrel_stage #(
  parameter int DEPTH  = 8,
  parameter int SHIFT  = 1,
  parameter int ROTATE = 0
) (
  input  logic [DEPTH-1:0] in,
  input  logic             en,
  output logic [DEPTH-1:0] out
);

  logic [SHIFT-1:0] wrap_s;
  logic [DEPTH-1:0] shifted_s;

  // Fill for the vacated low bits, then select shifted or pass-through word.
  always_comb begin
    wrap_s    = {SHIFT{1'b0}};
    shifted_s = in;
    out       = in;
    if (ROTATE != 0) begin
      wrap_s = in[DEPTH-1 -: SHIFT];
    end else begin
      wrap_s = {SHIFT{1'b0}};
    end
    shifted_s = {in[DEPTH-1-SHIFT:0], wrap_s};
    if (en) begin
      out = shifted_s;
    end else begin
      out = in;
    end
  end

endmodule

// File: rtl/barrel_shift.sv
// barrel_shift
//   Logarithmic barrel shifter with a single registered output. Shifts (or
//   rotates when ROTATE=1) a DEPTH-bit word by 0..DEPTH-1 positions per cycle.
//   Only left-shifting stages exist: a right shift bit-reverses the input,
//   shifts left, and bit-reverses the result.
// Ports
//   clk  input   1        rising-edge clock
//   rst  input   1        asynchronous active-high reset, clears Out
//   Di   input   1        1 = toward MSB, 0 = toward LSB
//   n    input   log2(DEPTH) shift amount
//   I    input   DEPTH    data to shift
//   Out  output  DEPTH    registered result, one cycle after inputs
module barrel_shift
  import barrel_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROTATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Di,
  input  logic [log2w(DEPTH)-1:0]   n,
  input  logic [DEPTH-1:0]          I,
  output logic [DEPTH-1:0]          Out
);

  localparam int NW = log2w(DEPTH);

  logic [DEPTH-1:0] pre_s;
  logic [DEPTH-1:0] stage_s [NW+1];
  logic [DEPTH-1:0] result_s;

  // Mirror the input for right shifts so the stages only ever shift left.
  always_comb begin
    pre_s = I;
    if (Di == DIR_RIGHT) begin
      for (int i = 0; i < DEPTH; i++) begin
        pre_s[i] = I[DEPTH-1-i];
      end
    end else begin
      pre_s = I;
    end
  end

  assign stage_s[0] = pre_s;

  for (genvar k = 0; k < NW; k++) begin : g_stage
    barrel_stage #(
      .DEPTH  (DEPTH),
      .SHIFT  (32'sd1 <<< k),
      .ROTATE (ROTATE)
    ) u_stage (
      .in  (stage_s[k]),
      .en  (n[k]),
      .out (stage_s[k+1])
    );
  end

  // Undo the input mirroring for right shifts.
  always_comb begin
    result_s = stage_s[NW];
    if (Di == DIR_RIGHT) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_s[i] = stage_s[NW][DEPTH-1-i];
      end
    end else begin
      result_s = stage_s[NW];
    end
  end

  // Output register; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Out <= {DEPTH{1'b0}};
    end else begin
      Out <= result_s;
    end
  end

endmodule

// File: tb/tb_barrel_shift.sv
// tb_barrel_shift
//   Drives four shifter instances (8-bit logical, 8-bit rotate, 4-bit logical,
//   32-bit rotate) every cycle; expected results are queued when inputs are
//   applied and compared one clock later.
module tb_barrel_shift;

  logic        clk;
  logic        rst;

  logic        di8;
  logic [2:0]  n8;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic [7:0]  out8r;

  logic        di4;
  logic [1:0]  n4;
  logic [3:0]  in4;
  logic [3:0]  out4;

  logic        di32;
  logic [4:0]  n32;
  logic [31:0] in32;
  logic [31:0] out32;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          unit;
  } sb_item_t;

  sb_item_t sb[$];

  barrel_shift #(.DEPTH(8), .ROTATE(0)) u_dut8 (
    .clk(clk), .rst(rst), .Di(di8), .n(n8), .I(in8), .Out(out8)
  );

  barrel_shift #(.DEPTH(8), .ROTATE(1)) u_dut8r (
    .clk(clk), .rst(rst), .Di(di8), .n(n8), .I(in8), .Out(out8r)
  );

  barrel_shift #(.DEPTH(4), .ROTATE(0)) u_dut4 (
    .clk(clk), .rst(rst), .Di(di4), .n(n4), .I(in4), .Out(out4)
  );

  barrel_shift #(.DEPTH(32), .ROTATE(1)) u_dut32 (
    .clk(clk), .rst(rst), .Di(di32), .n(n32), .I(in32), .Out(out32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the values differ.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural shift/rotate of a w-bit value held in the low bits of x.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int amt,
                                            input logic left, input bit rot, input int w);
    logic [63:0] v;
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    v    = {32'd0, x} & mask;
    if (left) r = (v << amt) | (rot ? (v >> (w - amt)) : 64'd0);
    else      r = (v >> amt) | (rot ? (v << (w - amt)) : 64'd0);
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic logic [31:0] get_out(input int unit);
    case (unit)
      0:       return {24'd0, out8};
      1:       return {24'd0, out8r};
      2:       return {28'd0, out4};
      3:       return out32;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Apply one vector to all instances, queue expectations, check after the edge.
  task automatic step(input logic [7:0] i8, input logic [2:0] a8, input logic d,
                      input logic [7:0] e8, input logic [7:0] e8r, input string tag);
    sb_item_t it;
    @(negedge clk);
    in8  = i8;
    n8   = a8;
    di8  = d;
    in4  = 4'($urandom);
    n4   = 2'($urandom);
    di4  = 1'($urandom);
    in32 = $urandom;
    n32  = 5'($urandom);
    di32 = 1'($urandom);
    sb.push_back('{tag, {24'd0, e8}, 0});
    sb.push_back('{{tag, "_rot"}, {24'd0, e8r}, 1});
    sb.push_back('{"rnd4", ref_shift({28'd0, in4}, int'(n4), di4, 1'b0, 4), 2});
    sb.push_back('{"rnd32", ref_shift(in32, int'(n32), di32, 1'b1, 32), 3});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, get_out(it.unit), it.exp);
    end
  endtask

  // Step with both 8-bit expectations taken from the behavioural model.
  task automatic step_model(input logic [7:0] i8, input logic [2:0] a8, input logic d, input string tag);
    logic [31:0] e;
    logic [31:0] er;
    e  = ref_shift({24'd0, i8}, int'(a8), d, 1'b0, 8);
    er = ref_shift({24'd0, i8}, int'(a8), d, 1'b1, 8);
    step(i8, a8, d, e[7:0], er[7:0], tag);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    logic [31:0] e;
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    di8  = 1'b0; n8  = 3'd0; in8  = 8'h00;
    di4  = 1'b0; n4  = 2'd0; in4  = 4'h0;
    di32 = 1'b0; n32 = 5'd0; in32 = 32'h0;

    // Reset state.
    #2;
    check("reset_out8",  {24'd0, out8},  32'd0);
    check("reset_out8r", {24'd0, out8r}, 32'd0);
    check("reset_out32", out32,          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed left shifts.
    step(8'b10110011, 3'd0, 1'b1, 8'b10110011, 8'b10110011, "shl_n0");
    step(8'b10110011, 3'd1, 1'b1, 8'b01100110, 8'b01100111, "shl_n1");
    step(8'b10110011, 3'd2, 1'b1, 8'b11001100, 8'b11001110, "shl_n2");
    step(8'b10110011, 3'd3, 1'b1, 8'b10011000, 8'b10011101, "shl_n3");
    // Directed right shifts.
    step(8'b10110011, 3'd1, 1'b0, 8'b01011001, 8'b11011001, "shr_n1");
    step(8'b10110011, 3'd2, 1'b0, 8'b00101100, 8'b11101100, "shr_n2");
    step(8'b10110011, 3'd3, 1'b0, 8'b00010110, 8'b01110110, "shr_n3");
    step(8'b10110011, 3'd7, 1'b0, 8'b00000001, 8'b01100111, "shr_n7");
    step(8'b10110011, 3'd0, 1'b0, 8'b10110011, 8'b10110011, "shr_n0");
    step(8'b10110011, 3'd7, 1'b1, 8'b10000000, 8'b11011001, "shl_n7");

    // Back-to-back: new I every cycle, result is previous I << 1.
    prev = 8'h00;
    for (int c = 0; c < 16; c++) begin
      cur = 8'($urandom);
      e   = ref_shift({24'd0, cur}, 1, 1'b1, 1'b1, 8);
      step(cur, 3'd1, 1'b1, {cur[6:0], 1'b0}, e[7:0], "stream");
      prev = cur;
    end

    // Exhaustive 8-bit sweep.
    for (int iv = 0; iv < 256; iv++) begin
      for (int nv = 0; nv < 8; nv++) begin
        for (int dv = 0; dv < 2; dv++) begin
          step_model(8'(iv), 3'(nv), 1'(dv), "exh");
        end
      end
    end

    // Asynchronous reset mid-cycle with a nonzero output.
    step(8'hFF, 3'd0, 1'b1, 8'hFF, 8'hFF, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out8",  {24'd0, out8},  32'd0);
    check("async_rst_out8r", {24'd0, out8r}, 32'd0);
    check("async_rst_out4",  {28'd0, out4},  32'd0);
    check("async_rst_out32", out32,          32'd0);
    @(posedge clk);
    #1;
    check("hold_rst_out8",  {24'd0, out8},  32'd0);
    check("hold_rst_out32", out32,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h5A, 3'd2, 1'b0, 8'h16, 8'h96, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
